// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Two-requester issue controller in front of a shared combinational ALU.
//   Round-robin arbitration picks one request in IDLE, the operation is held
//   on registered ALU inputs during EXEC (MUL/DIV for MULDIV_CYCLES cycles,
//   everything else for one), and the result is presented on a valid/ready
//   response port in RESP.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid / reqN_ready      request handshake, port N = 0/1
//   reqN_opcode/_a/_b/_shift     request payload
//   alu_opcode/_input1/_input2/
//   alu_shiftValue               registered drive to the ALU
//   alu_result/_carry/_zero/_sign  ALU outputs, sampled at the end of EXEC
//   rsp_valid / rsp_ready        response handshake
//   rsp_id/_result/_carry/_zero/
//   rsp_sign/_err                registered response payload
//   busy                         controller is not in IDLE
module alu_issue_ctrl #(
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned SHIFT_W       = 5,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [SHIFT_W-1:0] req0_shift,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_opcode,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [SHIFT_W-1:0] req1_shift,
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_sign,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd6;
  localparam logic [3:0] HOLD_MD = 4'(MULDIV_CYCLES - 1);

  state_t               state_q;
  logic                 prio_q;
  logic [3:0]           cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [SHIFT_W-1:0]   sh_q;
  logic                 id_q;

  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [WIDTH-1:0]     rsp_result_q;
  logic                 rsp_carry_q;
  logic                 rsp_zero_q;
  logic                 rsp_sign_q;
  logic                 rsp_err_q;

  logic                 gnt0;
  logic                 gnt1;
  logic [3:0]           op_d;
  logic [WIDTH-1:0]     a_d;
  logic [WIDTH-1:0]     b_d;
  logic [SHIFT_W-1:0]   sh_d;
  logic [3:0]           cnt_d;

  // Grant is a pure function of state, prio and the two valids. Gating with
  // rst keeps both ports closed while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    op_d  = gnt1 ? req1_opcode : req0_opcode;
    a_d   = gnt1 ? req1_a      : req0_a;
    b_d   = gnt1 ? req1_b      : req0_b;
    sh_d  = gnt1 ? req1_shift  : req0_shift;
    cnt_d = (op_d == OP_MUL || op_d == OP_DIV) ? HOLD_MD : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            id_q    <= gnt1;
            prio_q  <= ~gnt1;
            cnt_q   <= cnt_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            // Opcodes 12..15 have no ALU function; report them with a
            // cleared payload so stale ALU outputs never leak out.
            if (op_q >= 4'd12) begin
              rsp_result_q <= '0;
              rsp_carry_q  <= 1'b0;
              rsp_zero_q   <= 1'b0;
              rsp_sign_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
            end else begin
              rsp_result_q <= alu_result;
              rsp_carry_q  <= alu_carry;
              rsp_zero_q   <= alu_zero;
              rsp_sign_q   <= alu_sign;
              rsp_err_q    <= 1'b0;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready     = gnt0;
  assign req1_ready     = gnt1;
  assign alu_opcode     = op_q;
  assign alu_input1     = a_q;
  assign alu_input2     = b_q;
  assign alu_shiftValue = sh_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_carry      = rsp_carry_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_sign       = rsp_sign_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int unsigned W = 128;
  localparam int unsigned S = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_opcode, req1_opcode;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [S-1:0] req0_shift, req1_shift;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_input1, alu_input2, alu_result;
  logic [S-1:0] alu_shiftValue;
  logic         alu_carry, alu_zero, alu_sign;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_carry, rsp_zero, rsp_sign, rsp_err, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .SHIFT_W(S), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_sign(rsp_sign), .rsp_err(rsp_err), .busy(busy)
  );

  // Small stand-in for the ALU; unknown opcodes return all-ones with carry
  // so that the illegal-opcode masking is visible.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_opcode)
      4'd2:  alu_result = alu_input1 * alu_input2;
      4'd5:  alu_result = alu_input1 & alu_input2;
      4'd6:  alu_result = (alu_input2 != '0) ? alu_input1 / alu_input2 : '0;
      4'd10: alu_result = alu_input1 ^ alu_input2;
      default: begin
        alu_result = '1;
        alu_carry  = 1'b1;
      end
    endcase
    alu_zero = (alu_result == '0);
    alu_sign = alu_result[W-1];
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents a request at the current negedge, waits for its grant, and
  // returns at the negedge following the accept edge (cycle 1 of EXEC).
  task automatic send(input int p, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    if (p == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end
    #1;
    while (!((p == 0) ? req0_ready : req1_ready) && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 20) check("grant_timeout", t, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Counts cycles from the accept cycle (0) to the first rsp_valid cycle,
  // checking the ALU drive stays put while waiting.
  task automatic wait_rsp(input int exp_lat, input logic [3:0] op, input logic [W-1:0] a);
    int lat;
    lat = 1;
    #1;
    while (!rsp_valid && lat < 40) begin
      check("alu_op_hold", alu_opcode, op);
      check("alu_a_hold", alu_input1, a);
      @(negedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  int gnt_port[$];
  int gnt_cyc[$];
  int ids[$];

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_opcode = 4'd5; req1_opcode = 4'd5;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_shift = '0; req1_shift = '0;

    // Reset state, with both requesters pushing.
    @(negedge clk); @(negedge clk); #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_alu_a", alu_input1, 0);
    check("rst_alu_sh", alu_shiftValue, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // XOR on port 0.
    send(0, 4'd10, 128'hF0, 128'hFF);
    wait_rsp(2, 4'd10, 128'hF0);
    check("xor_result", rsp_result, 128'h0F);
    check("xor_id", rsp_id, 0);
    check("xor_zero", rsp_zero, 0);
    check("xor_err", rsp_err, 0);
    @(negedge clk); #1;
    check("xor_released", rsp_valid, 0);
    @(negedge clk);

    // MUL on port 0 (prio now points at port 1; a lone request still wins).
    send(0, 4'd2, 128'd3, 128'd5);
    wait_rsp(5, 4'd2, 128'd3);
    check("mul_result", rsp_result, 128'd15);
    check("mul_id", rsp_id, 0);
    @(negedge clk); @(negedge clk);

    // Illegal opcode on port 1.
    send(1, 4'd13, 128'h1234, 128'h5678);
    wait_rsp(2, 4'd13, 128'h1234);
    check("ill_err", rsp_err, 1);
    check("ill_result", rsp_result, 0);
    check("ill_carry", rsp_carry, 0);
    check("ill_zero", rsp_zero, 0);
    check("ill_sign", rsp_sign, 0);
    check("ill_id", rsp_id, 1);
    @(negedge clk); @(negedge clk);

    // Backpressure: XOR of equal operands (zero result) held for 10 cycles.
    rsp_ready = 1'b0;
    send(0, 4'd10, 128'h33, 128'h33);
    wait_rsp(2, 4'd10, 128'h33);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 0);
      check("bp_zero", rsp_zero, 1);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", rsp_valid, 1);
    @(negedge clk); #1;
    check("bp_released", rsp_valid, 0);
    check("bp_idle", busy, 0);

    // Dual continuous AND requests after reset.
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'd5; req0_a = 128'hFF00; req0_b = 128'h0FF0;
    req1_valid = 1'b1; req1_opcode = 4'd5; req1_a = 128'hAAAA; req1_b = 128'h00FF;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready && req1_ready) check("dual_both_ready", 1, 0);
      if (req0_ready) begin gnt_port.push_back(0); gnt_cyc.push_back(c); end
      if (req1_ready) begin gnt_port.push_back(1); gnt_cyc.push_back(c); end
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        check("dual_result", rsp_result, rsp_id ? 128'h00AA : 128'h0F00);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("dual_n_grants", gnt_port.size(), 4);
    check("dual_n_rsp", ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_port.size()) begin
        check("dual_grant_port", gnt_port[i], i % 2);
        check("dual_grant_cycle", gnt_cyc[i], 3 * i);
      end
      if (i < ids.size()) check("dual_rsp_id", ids[i], i % 2);
    end
    @(negedge clk); @(negedge clk);

    // Reset during the third EXEC cycle of a DIV.
    send(0, 4'd6, 128'd100, 128'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("divrst_busy", busy, 0);
    check("divrst_alu_op", alu_opcode, 0);
    check("divrst_alu_a", alu_input1, 0);
    check("divrst_alu_b", alu_input2, 0);
    check("divrst_rsp_valid", rsp_valid, 0);
    check("divrst_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("divrst_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    req0_valid = 1'b1; req0_opcode = 4'd5; req0_a = 128'hF0; req0_b = 128'h3C;
    req1_valid = 1'b1; req1_opcode = 4'd5; req1_a = 128'h0F; req1_b = 128'hFF;
    #1;
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(2, 4'd5, 128'hF0);
    check("post_rst_result", rsp_result, 128'h30);
    check("post_rst_id", rsp_id, 0);
    @(negedge clk); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Two-requester issue controller for the shared 128-bit combinational ALU. Arbitrates round-robin between two requester ports, registers the selected operation, and drives the ALU from registered operands. MUL and DIV are held stable for a programmable number of cycles as a multicycle path. The controller then returns result and flags on a single response port with valid/ready backpressure.

## Interface
- WIDTH, 128, operand/result width; must match the ALU instance.
- SHIFT_W, 5, shift amount width.
- MULDIV_CYCLES, 4, cycles the ALU inputs are held for MUL (opcode 2) and DIV (opcode 6); legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending on port 0 / 1.
- req0_ready / req1_ready  out  1  port accepts the request this cycle.
- req0_opcode / req1_opcode  in  4  ALU opcode.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_shift / req1_shift  in  SHIFT_W  rotate amount.
- alu_opcode  out  4  to the ALU opcode input.
- alu_input1, alu_input2  out  WIDTH  to the ALU operand inputs.
- alu_shiftValue  out  SHIFT_W  to the ALU shift input.
- alu_result  in  WIDTH  from the ALU.
- alu_carry, alu_zero, alu_sign  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  WIDTH  captured result.
- rsp_carry, rsp_zero, rsp_sign  out  1  captured flags.
- rsp_err  out  1  illegal opcode (12..15).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Round-robin pointer `prio` selects the preferred port when both are valid. A single valid port always wins.
  - Only the granted port sees ready=1. Ready is combinational from the FSM state and the valid inputs; it never depends on the other port's ready.
  - On handshake: latch opcode, operands, shift and id into registers. Set `prio` to the other port.
  - Load the hold counter with MULDIV_CYCLES-1 for opcodes 2 and 6, otherwise 0. Go to EXEC.
- EXEC:
  - alu_* outputs are driven from the registers and stay stable for the whole state.
  - Counter nonzero: decrement.
  - Counter zero: capture alu_result and flags into the rsp_* registers, set rsp_err=0, go to RESP.
  - Illegal opcode (12..15): capture result=0, carry=0, zero=0, sign=0, rsp_err=1, regardless of the ALU outputs.
- RESP:
  - rsp_valid=1. All rsp_* outputs are held until rsp_valid && rsp_ready.
  - On that handshake go to IDLE. A new request cannot be accepted in the same cycle.
- Requesters may drop valid before the handshake; the grant is re-evaluated every IDLE cycle.
- Requests are never reordered or dropped once accepted, except on reset.

## Timing
- Reset (async assert, sync release):
  - State IDLE, prio=0, counter=0.
  - req*_ready=0 and busy=0. No request is accepted while rst is high.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry/zero/sign/err=0.
  - alu_opcode=0, alu_input1/2=0, alu_shiftValue=0.
- Latency, accept edge to first rsp_valid cycle:
  - 2 cycles for non-MUL/DIV opcodes.
  - 1+MULDIV_CYCLES cycles for MUL and DIV.
- Best-case issue interval: 3 cycles (non-MUL/DIV) with rsp_ready tied high.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is produced, and all outputs take their reset values.
- Both ports valid on the same cycle: port `prio` wins. Sustained dual requests alternate 0,1,0,1 starting from port 0 after reset.
- rsp_ready held low: the FSM stays in RESP indefinitely with outputs stable, and both req*_ready stay 0.

## Test plan
- After reset: single XOR (opcode 10), a=0xF0, b=0xFF on port 0 -> rsp_valid 2 cycles after accept; rsp_result=0x0F, rsp_id=0, rsp_zero=0, rsp_err=0.
- MUL (opcode 2), a=3, b=5, MULDIV_CYCLES=4 -> alu_* stable for 4 EXEC cycles; rsp_valid 5 cycles after accept; rsp_result=15.
- Both ports continuously valid with AND (opcode 5) -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one accept every 3 cycles with rsp_ready=1.
- Opcode 13 on port 1 -> rsp_err=1, rsp_result=0, all flags 0, rsp_id=1.
- rsp_ready held low for 10 cycles during RESP -> rsp_* stable, req*_ready=0 and busy=1 throughout; response released on the first cycle rsp_ready=1.
- rst asserted during the third EXEC cycle of a DIV -> outputs immediately at reset values; no rsp_valid appears for that DIV; the next request is serviced normally, with port 0 as priority.
